// File: rtl/minmax_window_pkg.sv
// -----------------------------------------------------------------------------
// minmax_window_pkg
//   Shared definitions for the windowed min/max tracker:
//     - DATA_W / CNT_W : sample width and index/count width (both 4 bits)
//     - state_t        : tracker state (IDLE = empty, ACCUM = partial window,
//                        DONE = result held on the output handshake)
// -----------------------------------------------------------------------------
package minmax_window_pkg;

  localparam int DATA_W = 4;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage : minmax_window_pkg

// File: rtl/minmax_window_cmp.sv
// -----------------------------------------------------------------------------
// minmax_window_cmp
//   4-bit cascaded magnitude comparator (7485-style). Compares i_a against i_b
//   from the MSB down; when the two words are equal the cascade inputs are
//   passed through so several stages can be chained.
//
//   Ports:
//     i_a, i_b          in  [DATA_W]  unsigned operands
//     i_gt, i_eq, i_lt  in  1         cascade inputs from a less-significant
//                                     stage (tie to 0/1/0 for a single stage)
//     o_gt, o_eq, o_lt  out 1         a>b, a==b, a<b (exactly one is high)
// -----------------------------------------------------------------------------
module minmax_window_cmp
  import minmax_window_pkg::*;
(
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic              i_gt,
  input  logic              i_eq,
  input  logic              i_lt,
  output logic              o_gt,
  output logic              o_eq,
  output logic              o_lt
);

  always_comb begin
    // NOTE: every output gets a value before any branch, so no path through
    // this block can leave an output unassigned and infer a latch.
    o_gt = i_gt;
    o_eq = i_eq;
    o_lt = i_lt;
    // Walk LSB to MSB so that the most significant differing bit decides last.
    for (int i = 0; i < DATA_W; i++) begin
      if (i_a[i] && !i_b[i]) begin
        o_gt = 1'b1;
        o_eq = 1'b0;
        o_lt = 1'b0;
      end else if (!i_a[i] && i_b[i]) begin
        o_gt = 1'b0;
        o_eq = 1'b0;
        o_lt = 1'b1;
      end
    end
  end

endmodule : minmax_window_cmp

// File: rtl/minmax_window.sv
// -----------------------------------------------------------------------------
// minmax_window
//   Windowed min/max tracker for 4-bit unsigned samples. Samples arrive on a
//   valid/ready handshake; each one is compared against the running maximum and
//   minimum by two cascaded magnitude comparators. After WINDOW accepted
//   samples the window maximum, minimum and index of the first maximum are
//   presented on a valid/ready output and held until the consumer takes them.
//
//   Optional feature (macro MINMAX_EQ_COUNT_EN): adds out_eq_cnt, the number of
//   samples in the window equal to the maximum.
//
//   Parameters:
//     WINDOW       samples per window, legal range 2..15
//   Ports:
//     clk          in   1       rising-edge clock
//     rst_n        in   1       asynchronous reset, active low
//     clear        in   1       synchronous abort of partial window / result
//     in_valid     in   1       sample present
//     in_ready     out  1       block can accept a sample
//     in_data      in   4       unsigned sample
//     out_valid    out  1       result present
//     out_ready    in   1       consumer accepts the result
//     out_max      out  4       window maximum
//     out_min      out  4       window minimum
//     out_max_idx  out  4       0-based index of the first maximum
//     out_eq_cnt   out  4       samples equal to the maximum (macro only)
// -----------------------------------------------------------------------------
module minmax_window
  import minmax_window_pkg::*;
#(
  parameter int WINDOW = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_max,
  output logic [DATA_W-1:0] out_min,
  output logic [CNT_W-1:0]  out_max_idx
`ifdef MINMAX_EQ_COUNT_EN
  ,
  output logic [CNT_W-1:0]  out_eq_cnt
`endif
);

  // Running state
  state_t              r_state;
  logic [CNT_W-1:0]    r_n;
  logic [DATA_W-1:0]   r_max;
  logic [DATA_W-1:0]   r_min;
  logic [CNT_W-1:0]    r_idx;

  // Result registers, loaded only on entry to DONE
  logic [DATA_W-1:0]   r_out_max;
  logic [DATA_W-1:0]   r_out_min;
  logic [CNT_W-1:0]    r_out_idx;

  // Comparator results
  logic w_max_gt, w_max_eq, w_max_lt;
  logic w_min_gt, w_min_eq, w_min_lt;

  logic                w_accept;
  logic                w_first;
  logic                w_last;
  logic [DATA_W-1:0]   w_nxt_max;
  logic [DATA_W-1:0]   w_nxt_min;
  logic [CNT_W-1:0]    w_nxt_idx;

  minmax_window_cmp u_cmp_max (
    .i_a  (in_data),
    .i_b  (r_max),
    .i_gt (1'b0),
    .i_eq (1'b1),
    .i_lt (1'b0),
    .o_gt (w_max_gt),
    .o_eq (w_max_eq),
    .o_lt (w_max_lt)
  );

  minmax_window_cmp u_cmp_min (
    .i_a  (in_data),
    .i_b  (r_min),
    .i_gt (1'b0),
    .i_eq (1'b1),
    .i_lt (1'b0),
    .o_gt (w_min_gt),
    .o_eq (w_min_eq),
    .o_lt (w_min_lt)
  );

  // Handshake flags come from the state register alone.
  assign in_ready  = (r_state != DONE);
  assign out_valid = (r_state == DONE);

  assign w_accept = in_valid && in_ready;
  assign w_first  = (r_state == IDLE);
  // WINDOW >= 2 keeps this false in IDLE, where r_n is always 0.
  assign w_last   = (r_state == ACCUM) && (r_n == CNT_W'(WINDOW - 1));

  always_comb begin
    w_nxt_max = r_max;
    w_nxt_min = r_min;
    w_nxt_idx = r_idx;
    if (w_first) begin
      w_nxt_max = in_data;
      w_nxt_min = in_data;
      w_nxt_idx = '0;
    end else begin
      // Only a strict G moves the maximum; ties keep the first index.
      case ({w_max_gt, w_max_eq, w_max_lt})
        3'b100: begin
          w_nxt_max = in_data;
          w_nxt_idx = r_n;
        end
        default: ;
      endcase
      case ({w_min_gt, w_min_eq, w_min_lt})
        3'b001:  w_nxt_min = in_data;
        default: ;
      endcase
    end
  end

`ifdef MINMAX_EQ_COUNT_EN
  logic [CNT_W-1:0] r_eq;
  logic [CNT_W-1:0] r_out_eq;
  logic [CNT_W-1:0] w_nxt_eq;

  always_comb begin
    w_nxt_eq = r_eq;
    if (w_first || w_max_gt) begin
      w_nxt_eq = CNT_W'(1);
    end else if (w_max_eq) begin
      w_nxt_eq = r_eq + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_eq     <= '0;
      r_out_eq <= '0;
    end else if (!clear && w_accept) begin
      r_eq <= w_nxt_eq;
      if (w_last) begin
        r_out_eq <= w_nxt_eq;
      end
    end
  end

  assign out_eq_cnt = r_out_eq;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments so every register in
    // this block samples the pre-edge values, independent of statement order.
    if (!rst_n) begin
      r_state   <= IDLE;
      r_n       <= '0;
      r_max     <= '0;
      r_min     <= '0;
      r_idx     <= '0;
      r_out_max <= '0;
      r_out_min <= '0;
      r_out_idx <= '0;
    end else if (clear) begin
      // Abort wins over both handshakes; the last result stays on out_*.
      r_state <= IDLE;
      r_n     <= '0;
    end else begin
      case (r_state)
        IDLE, ACCUM: begin
          if (w_accept) begin
            r_max <= w_nxt_max;
            r_min <= w_nxt_min;
            r_idx <= w_nxt_idx;
            if (w_last) begin
              r_state   <= DONE;
              r_n       <= '0;
              r_out_max <= w_nxt_max;
              r_out_min <= w_nxt_min;
              r_out_idx <= w_nxt_idx;
            end else begin
              r_state <= ACCUM;
              r_n     <= r_n + CNT_W'(1);
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign out_max     = r_out_max;
  assign out_min     = r_out_min;
  assign out_max_idx = r_out_idx;

endmodule : minmax_window

// File: tb/tb_minmax_window.sv
// -----------------------------------------------------------------------------
// tb_minmax_window
//   Self-checking bench for minmax_window (WINDOW=8). Expected results come
//   from a reference model that evaluates each window's sample list directly:
//   largest value, smallest value, position of its first occurrence and the
//   number of occurrences. Inputs change and outputs are sampled on the
//   falling clock edge. Build with +define+MINMAX_EQ_COUNT_EN to also check
//   out_eq_cnt.
// -----------------------------------------------------------------------------
module tb_minmax_window;

  localparam int WINDOW = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clear;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_max;
  logic [3:0] out_min;
  logic [3:0] out_max_idx;
`ifdef MINMAX_EQ_COUNT_EN
  logic [3:0] out_eq_cnt;
`endif

  minmax_window #(.WINDOW(WINDOW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (clear),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_max     (out_max),
    .out_min     (out_min),
    .out_max_idx (out_max_idx)
`ifdef MINMAX_EQ_COUNT_EN
    ,
    .out_eq_cnt  (out_eq_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [3:0] e_max, e_min, e_idx;
`ifdef MINMAX_EQ_COUNT_EN
  logic [3:0] e_cnt;
`endif
  logic [3:0] q[$];

  // ---------------- reference model ----------------
  function automatic logic [3:0] f_max(input logic [3:0] s[$]);
    int m = 0;
    foreach (s[i]) if (int'(s[i]) > m) m = int'(s[i]);
    return 4'(m);
  endfunction

  function automatic logic [3:0] f_min(input logic [3:0] s[$]);
    int m = 15;
    foreach (s[i]) if (int'(s[i]) < m) m = int'(s[i]);
    return 4'(m);
  endfunction

  function automatic logic [3:0] f_idx(input logic [3:0] s[$]);
    logic [3:0] m = f_max(s);
    for (int i = 0; i < s.size(); i++) if (s[i] == m) return 4'(i);
    return 4'd0;
  endfunction

  function automatic logic [3:0] f_cnt(input logic [3:0] s[$]);
    logic [3:0] m = f_max(s);
    int c = 0;
    foreach (s[i]) if (s[i] == m) c++;
    return 4'(c);
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_values(input string tag);
    check({tag, ":max"}, {4'd0, out_max}, {4'd0, e_max});
    check({tag, ":min"}, {4'd0, out_min}, {4'd0, e_min});
    check({tag, ":idx"}, {4'd0, out_max_idx}, {4'd0, e_idx});
`ifdef MINMAX_EQ_COUNT_EN
    check({tag, ":eq_cnt"}, {4'd0, out_eq_cnt}, {4'd0, e_cnt});
`endif
  endtask

  task automatic check_result(input string tag);
    check({tag, ":out_valid"}, {7'd0, out_valid}, 8'd1);
    check({tag, ":in_ready"}, {7'd0, in_ready}, 8'd0);
    check_values(tag);
  endtask

  // One sample: block must be ready with no result pending; accepted at the
  // next rising edge.
  task automatic push(input logic [3:0] d, input string tag);
    check({tag, ":in_ready_pre"}, {7'd0, in_ready}, 8'd1);
    check({tag, ":out_valid_pre"}, {7'd0, out_valid}, 8'd0);
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 4'($urandom_range(0, 15));
  endtask

  task automatic run_window(input logic [3:0] s[$], input bit gaps, input string tag);
    e_max = f_max(s);
    e_min = f_min(s);
    e_idx = f_idx(s);
`ifdef MINMAX_EQ_COUNT_EN
    e_cnt = f_cnt(s);
`endif
    foreach (s[i]) begin
      if (gaps && i > 0) @(negedge clk);
      push(s[i], tag);
    end
    check_result(tag);
  endtask

  task automatic fill_random(input int range_hi);
    q.delete();
    for (int i = 0; i < WINDOW; i++) q.push_back(4'($urandom_range(0, range_hi)));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n     = 1'b0;
    clear     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 4'd0;
    out_ready = 1'b0;

    // Reset values while rst_n is held low
    #12;
    check("reset:out_valid", {7'd0, out_valid}, 8'd0);
    e_max = 4'd0; e_min = 4'd0; e_idx = 4'd0;
`ifdef MINMAX_EQ_COUNT_EN
    e_cnt = 4'd0;
`endif
    check_values("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset:in_ready", {7'd0, in_ready}, 8'd1);

    // Mixed window with the consumer always ready: result visible one cycle
    out_ready = 1'b1;
    q = {4'd3, 4'd9, 4'd1, 4'd9, 4'd15, 4'd0, 4'd7, 4'd15};
    run_window(q, 1'b0, "mixed");
    @(negedge clk);
    check("mixed:valid_one_cycle", {7'd0, out_valid}, 8'd0);
    check("mixed:in_ready_after", {7'd0, in_ready}, 8'd1);
    check_values("mixed_held_idle");

    // Constant window followed by 5 cycles of output backpressure, with
    // samples offered that must not be consumed
    out_ready = 1'b0;
    q.delete();
    for (int i = 0; i < WINDOW; i++) q.push_back(4'd5);
    run_window(q, 1'b0, "const");
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1;
      in_data  = 4'd15;
      @(negedge clk);
      check_result("backpressure");
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("release:out_valid", {7'd0, out_valid}, 8'd0);
    check("release:in_ready", {7'd0, in_ready}, 8'd1);

    // Mid-window clear; the sample offered with clear is dropped too
    push(4'd2, "pre_clear");
    push(4'd14, "pre_clear");
    push(4'd6, "pre_clear");
    clear    = 1'b1;
    in_valid = 1'b1;
    in_data  = 4'd15;
    @(negedge clk);
    clear    = 1'b0;
    in_valid = 1'b0;
    check("clear:out_valid", {7'd0, out_valid}, 8'd0);
    check("clear:in_ready", {7'd0, in_ready}, 8'd1);
    check_values("clear_held");
    q = {4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8};
    run_window(q, 1'b0, "after_clear");
    @(negedge clk);

    // Clear while a result is pending drops the result, keeps out_* values
    out_ready = 1'b0;
    fill_random(15);
    run_window(q, 1'b0, "pre_clear_done");
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("clear_done:out_valid", {7'd0, out_valid}, 8'd0);
    check("clear_done:in_ready", {7'd0, in_ready}, 8'd1);
    check_values("clear_done_held");

    // Stalled window: in_valid every other cycle
    out_ready = 1'b1;
    q = {4'd3, 4'd9, 4'd1, 4'd9, 4'd15, 4'd0, 4'd7, 4'd15};
    run_window(q, 1'b1, "stall");
    @(negedge clk);

    // Random windows, some with narrow value ranges to force ties, and a
    // random consumer delay
    for (int w = 0; w < 12; w++) begin
      int dly;
      out_ready = 1'b0;
      fill_random((w % 3 == 0) ? 3 : 15);
      run_window(q, bit'($urandom_range(0, 1)), "random");
      dly = $urandom_range(0, 3);
      for (int c = 0; c < dly; c++) begin
        @(negedge clk);
        check("random:hold_valid", {7'd0, out_valid}, 8'd1);
      end
      out_ready = 1'b1;
      @(negedge clk);
      check("random:ack", {7'd0, out_valid}, 8'd0);
    end

    // Asynchronous reset while DONE
    out_ready = 1'b0;
    fill_random(15);
    run_window(q, 1'b0, "pre_reset");
    #2 rst_n = 1'b0;
    #1;
    check("async_rst:out_valid", {7'd0, out_valid}, 8'd0);
    e_max = 4'd0; e_min = 4'd0; e_idx = 4'd0;
`ifdef MINMAX_EQ_COUNT_EN
    e_cnt = 4'd0;
`endif
    check_values("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst:in_ready", {7'd0, in_ready}, 8'd1);
    check("post_rst:out_valid", {7'd0, out_valid}, 8'd0);

    // Block still works after reset
    out_ready = 1'b1;
    fill_random(15);
    run_window(q, 1'b0, "post_rst_window");
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_minmax_window
